sw_reg_bank: RTL and testbench

- Parametrised multi-channel Wishbone software register bank; successor to the single read-only software register.
- C_NUM_REGS channels, each either read (fabric -> software, snapshot on capture strobe) or write (software -> fabric, byte-lane writes with update pulse).
- Registered one-cycle ack, error response for bad address or illegal write.
- Sits between the Wishbone interconnect and fabric logic in the same clock domain.

---
 rtl/sw_reg_pkg.sv | 35 +++
 rtl/sw_reg_chan.sv | 58 +++++
 rtl/sw_reg_bank.sv | 125 ++++++++++++
 tb/tb_sw_reg_bank.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sw_reg_pkg.sv
// Shared types and helpers for the software register bank: FSM encoding,
// byte-lane count, address-to-channel mapping and byte-lane merging.
package sw_reg_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    localparam int BYTE_LANES = 4;

    // Channel index of a byte address; the two low address bits drop out.
    function automatic logic [31:0] addr_to_idx(input logic [31:0] adr,
                                                input logic [31:0] base);
        return (adr - base) >> 2;
    endfunction

    // Replace the selected bytes of cur with wdata. Lanes starting at or
    // beyond data_w are left alone; a lane straddling data_w is merged and
    // the caller truncates to its width.
    function automatic logic [31:0] merge_lanes(input logic [31:0]           cur,
                                                input logic [31:0]           wdata,
                                                input logic [BYTE_LANES-1:0] sel,
                                                input int                    data_w);
        logic [31:0] res;
        res = cur;
        for (int b = 0; b < BYTE_LANES; b++) begin
            if (sel[b] && ((b * 8) < data_w)) begin
                res[b*8 +: 8] = wdata[b*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sw_reg_chan.sv
// One channel of the register bank. A write channel is loaded by software
// through byte-lane writes; a read channel snapshots its fabric source on
// the capture strobe. Either way the held value is exposed for readback.
module sw_reg_chan
    import sw_reg_pkg::*;
#(
    parameter int          C_DATA_W  = 32,
    parameter bit          C_IS_WR   = 1'b0,
    parameter logic [31:0] C_RST_VAL = 32'h00000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  capture,
    input  logic                  wr_en,
    input  logic [BYTE_LANES-1:0] sel,
    input  logic [31:0]           wdata,
    input  logic [C_DATA_W-1:0]   din,
    output logic [C_DATA_W-1:0]   value
);

    logic [31:0] cur_ext;
    logic [31:0] merged;
    logic        unused_sink;

    // Zero-extend the held value and merge the enabled write lanes over it.
    always_comb begin
        cur_ext                 = '0;
        cur_ext[C_DATA_W-1:0]   = value;
        merged                  = merge_lanes(cur_ext, wdata, sel, C_DATA_W);
    end

    // Only one of the two load paths exists per channel; the other inputs
    // and the merged bits above C_DATA_W are intentionally dropped.
    assign unused_sink = ^{merged, capture, din, wr_en};

    generate
        if (C_IS_WR) begin : g_wr
            // Software-written register with byte-lane update.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    value <= C_RST_VAL[C_DATA_W-1:0];
                end else if (wr_en) begin
                    value <= merged[C_DATA_W-1:0];
                end
            end
        end else begin : g_rd
            // Fabric shadow register loaded on the capture strobe.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    value <= C_RST_VAL[C_DATA_W-1:0];
                end else if (capture) begin
                    value <= din;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/sw_reg_bank.sv
// Multi-channel Wishbone software register bank. Decodes a byte address to a
// channel, performs the access on the IDLE edge, and answers with a
// registered one-cycle ack or err in the following cycle.
module sw_reg_bank
    import sw_reg_pkg::*;
#(
    parameter logic [31:0]           C_BASEADDR = 32'h00000000,
    parameter logic [31:0]           C_HIGHADDR = 32'h0000FFFF,
    parameter int                    C_NUM_REGS = 4,
    parameter int                    C_DATA_W   = 32,
    parameter logic [C_NUM_REGS-1:0] C_WR_MASK  = '0,
    parameter logic [31:0]           C_RST_VAL  = 32'h00000000
) (
    input  logic                           wbs_clk_i,
    input  logic                           wbs_rst_n_i,
    input  logic                           wbs_cyc_i,
    input  logic                           wbs_stb_i,
    input  logic                           wbs_we_i,
    input  logic [3:0]                     wbs_sel_i,
    input  logic [31:0]                    wbs_adr_i,
    input  logic [31:0]                    wbs_dat_i,
    output logic [31:0]                    wbs_dat_o,
    output logic                           wbs_ack_o,
    output logic                           wbs_err_o,
    input  logic                           fabric_capture_i,
    input  logic [C_NUM_REGS*C_DATA_W-1:0] fabric_data_in,
    output logic [C_NUM_REGS*C_DATA_W-1:0] fabric_data_out,
    output logic [C_NUM_REGS-1:0]          fabric_wr_stb,
    output logic [C_NUM_REGS-1:0]          fabric_rd_stb
);

    localparam logic [31:0] SPAN = C_HIGHADDR - C_BASEADDR;

    state_t                  state;
    logic                    req;
    logic                    hit;
    logic                    tgt_wr;
    logic [31:0]             offset;
    logic [31:0]             idx;
    logic [31:0]             rd_data;
    logic [C_NUM_REGS-1:0]   onehot;
    logic [C_NUM_REGS-1:0]   wr_en;
    logic [C_DATA_W-1:0]     chan_val [C_NUM_REGS];

    // Address decode and readback select. An address below the base wraps
    // the offset past SPAN, so a single compare covers both range bounds.
    always_comb begin
        req     = (state == IDLE) && wbs_cyc_i && wbs_stb_i;
        offset  = wbs_adr_i - C_BASEADDR;
        idx     = addr_to_idx(wbs_adr_i, C_BASEADDR);
        hit     = (offset <= SPAN) && (idx < 32'(C_NUM_REGS));
        onehot  = '0;
        rd_data = '0;
        tgt_wr  = 1'b0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            if (hit && (idx == 32'(i))) begin
                onehot[i]              = 1'b1;
                rd_data[C_DATA_W-1:0]  = chan_val[i];
                tgt_wr                 = C_WR_MASK[i];
            end
        end
        wr_en = (req && wbs_we_i) ? (onehot & C_WR_MASK) : '0;
    end

    genvar gi;
    generate
        for (gi = 0; gi < C_NUM_REGS; gi++) begin : g_chan
            sw_reg_chan #(
                .C_DATA_W  (C_DATA_W),
                .C_IS_WR   (C_WR_MASK[gi]),
                .C_RST_VAL (C_RST_VAL)
            ) u_chan (
                .clk     (wbs_clk_i),
                .rst_n   (wbs_rst_n_i),
                .capture (fabric_capture_i),
                .wr_en   (wr_en[gi]),
                .sel     (wbs_sel_i),
                .wdata   (wbs_dat_i),
                .din     (fabric_data_in[gi*C_DATA_W +: C_DATA_W]),
                .value   (chan_val[gi])
            );

            assign fabric_data_out[gi*C_DATA_W +: C_DATA_W] =
                C_WR_MASK[gi] ? chan_val[gi] : '0;
        end
    endgenerate

    // Two-state bus FSM with registered response, read data and strobes.
    always_ff @(posedge wbs_clk_i or negedge wbs_rst_n_i) begin
        if (!wbs_rst_n_i) begin
            state         <= IDLE;
            wbs_ack_o     <= 1'b0;
            wbs_err_o     <= 1'b0;
            wbs_dat_o     <= '0;
            fabric_wr_stb <= '0;
            fabric_rd_stb <= '0;
        end else begin
            wbs_ack_o     <= 1'b0;
            wbs_err_o     <= 1'b0;
            fabric_wr_stb <= '0;
            fabric_rd_stb <= '0;
            case (state)
                IDLE: begin
                    if (req) begin
                        state <= RESP;
                        if (!hit || (wbs_we_i && !tgt_wr)) begin
                            wbs_err_o <= 1'b1;
                            wbs_dat_o <= '0;
                        end else if (wbs_we_i) begin
                            wbs_ack_o     <= 1'b1;
                            fabric_wr_stb <= onehot;
                        end else begin
                            wbs_ack_o     <= 1'b1;
                            wbs_dat_o     <= rd_data;
                            fabric_rd_stb <= onehot;
                        end
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sw_reg_bank.sv
// Bench for sw_reg_bank: a 32-bit bank with two read and two write channels,
// plus a 12-bit all-write bank for width truncation and mid-access reset.
module tb_sw_reg_bank;

    logic         clk;
    // 32-bit bank, channels 2,3 write, 0,1 read
    logic         rst_n, cyc, stb, we, cap;
    logic [3:0]   sel;
    logic [31:0]  adr, wdat, dat_o;
    logic         ack, err;
    logic [127:0] din, dout;
    logic [3:0]   wr_stb, rd_stb;
    // 12-bit bank, all write channels
    logic         rst_n_b, cyc_b, stb_b, we_b, cap_b;
    logic [3:0]   sel_b;
    logic [31:0]  adr_b, wdat_b, dat_o_b;
    logic         ack_b, err_b;
    logic [47:0]  din_b, dout_b;
    logic [3:0]   wr_stb_b, rd_stb_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: value each channel of the 32-bit bank should hold,
    // and the value the read data bus should be holding.
    logic [31:0] mdl [4];
    logic [31:0] last_dat;

    sw_reg_bank #(
        .C_NUM_REGS (4), .C_DATA_W (32), .C_WR_MASK (4'b1100), .C_RST_VAL (32'h12345678)
    ) dut (
        .wbs_clk_i (clk), .wbs_rst_n_i (rst_n), .wbs_cyc_i (cyc), .wbs_stb_i (stb),
        .wbs_we_i (we), .wbs_sel_i (sel), .wbs_adr_i (adr), .wbs_dat_i (wdat),
        .wbs_dat_o (dat_o), .wbs_ack_o (ack), .wbs_err_o (err),
        .fabric_capture_i (cap), .fabric_data_in (din), .fabric_data_out (dout),
        .fabric_wr_stb (wr_stb), .fabric_rd_stb (rd_stb)
    );

    sw_reg_bank #(
        .C_NUM_REGS (4), .C_DATA_W (12), .C_WR_MASK (4'b1111), .C_RST_VAL (32'h12345678)
    ) dut_b (
        .wbs_clk_i (clk), .wbs_rst_n_i (rst_n_b), .wbs_cyc_i (cyc_b), .wbs_stb_i (stb_b),
        .wbs_we_i (we_b), .wbs_sel_i (sel_b), .wbs_adr_i (adr_b), .wbs_dat_i (wdat_b),
        .wbs_dat_o (dat_o_b), .wbs_ack_o (ack_b), .wbs_err_o (err_b),
        .fabric_capture_i (cap_b), .fabric_data_in (din_b), .fabric_data_out (dout_b),
        .fabric_wr_stb (wr_stb_b), .fabric_rd_stb (rd_stb_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One complete access on the 32-bit bank; strobe dropped during RESP.
    task automatic bus_a(input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input bit c,
                         output logic r_ack, output logic r_err, output logic [31:0] r_dat,
                         output logic [3:0] r_rd, output logic [3:0] r_wr, output logic r_late);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s; cap = c;
        @(posedge clk); #1;
        r_ack = ack; r_err = err; r_dat = dat_o; r_rd = rd_stb; r_wr = wr_stb;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; cap = 1'b0;
        @(posedge clk); #1;
        r_late = ack | err | (|rd_stb) | (|wr_stb);
    endtask

    // Software write as seen by a register: each selected byte replaced.
    function automatic logic [31:0] lane_write(input logic [31:0] old, input logic [31:0] d,
                                               input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (s[b]) r = (r & ~(32'hFF << (8 * b))) | (d & (32'hFF << (8 * b)));
        return r;
    endfunction

    task automatic test_reset();
        logic [31:0] r_dat;
        logic [3:0]  r_rd, r_wr;
        logic        r_ack, r_err, r_late;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if ((ack | err) !== 1'b0) begin
                n_fail++; $display("FAIL reset_no_ack: ack=%b err=%b required 0", ack, err);
            end
        end
        n_checks++;
        if (dat_o !== 32'h0) begin
            n_fail++; $display("FAIL reset_dat: got %h required 0", dat_o);
        end
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        rst_n = 1'b1; rst_n_b = 1'b1;
        for (int i = 0; i < 4; i++) mdl[i] = 32'h12345678;
        last_dat = 32'h0;
        n_checks++;
        if (dout !== {32'h12345678, 32'h12345678, 64'h0}) begin
            n_fail++; $display("FAIL reset_fabric_out: got %h required %h", dout,
                               {32'h12345678, 32'h12345678, 64'h0});
        end
        for (int i = 0; i < 4; i++) begin
            bus_a(1'b0, 32'(i * 4), 32'h0, 4'h0, 1'b0, r_ack, r_err, r_dat, r_rd, r_wr, r_late);
            n_checks++;
            if (r_ack !== 1'b1 || r_err !== 1'b0 || r_dat !== 32'h12345678) begin
                n_fail++; $display("FAIL reset_read ch%0d: ack=%b err=%b dat=%h required ack=1 dat=12345678",
                                   i, r_ack, r_err, r_dat);
            end
        end
        last_dat = 32'h12345678;
    endtask

    task automatic test_capture();
        logic [31:0] r_dat;
        logic [3:0]  r_rd, r_wr;
        logic        r_ack, r_err, r_late;
        @(negedge clk);
        din = {32'h44444444, 32'h33333333, 32'h22222222, 32'hEEEEFFFF};
        cap = 1'b1;
        @(negedge clk);
        cap = 1'b0;
        mdl[0] = 32'hEEEEFFFF; mdl[1] = 32'h22222222;
        bus_a(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, r_ack, r_err, r_dat, r_rd, r_wr, r_late);
        n_checks++;
        if (r_ack !== 1'b1 || r_dat !== 32'hEEEEFFFF || r_rd !== 4'b0001 || r_late !== 1'b0) begin
            n_fail++; $display("FAIL capture_read: ack=%b dat=%h rd=%b late=%b required 1 eeeeffff 0001 0",
                               r_ack, r_dat, r_rd, r_late);
        end
        din[31:0] = 32'h01020304;
        bus_a(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, r_ack, r_err, r_dat, r_rd, r_wr, r_late);
        n_checks++;
        if (r_dat !== 32'hEEEEFFFF) begin
            n_fail++; $display("FAIL capture_hold: got %h required eeeeffff", r_dat);
        end
        bus_a(1'b0, 32'h4, 32'h0, 4'h0, 1'b0, r_ack, r_err, r_dat, r_rd, r_wr, r_late);
        n_checks++;
        if (r_dat !== 32'h22222222 || r_rd !== 4'b0010) begin
            n_fail++; $display("FAIL capture_ch1: dat=%h rd=%b required 22222222 0010", r_dat, r_rd);
        end
        last_dat = 32'h22222222;
    endtask

    task automatic test_write();
        logic [31:0] r_dat;
        logic [3:0]  r_rd, r_wr;
        logic        r_ack, r_err, r_late;
        bus_a(1'b1, 32'h8, 32'h0, 4'hF, 1'b0, r_ack, r_err, r_dat, r_rd, r_wr, r_late);
        bus_a(1'b1, 32'h8, 32'hAABBCCDD, 4'b0101, 1'b0, r_ack, r_err, r_dat, r_rd, r_wr, r_late);
        n_checks++;
        if (r_ack !== 1'b1 || r_err !== 1'b0 || r_wr !== 4'b0100 || r_rd !== 4'b0000) begin
            n_fail++; $display("FAIL write_resp: ack=%b err=%b wr=%b rd=%b required 1 0 0100 0000",
                               r_ack, r_err, r_wr, r_rd);
        end
        n_checks++;
        if (dout[95:64] !== 32'h00BB00DD) begin
            n_fail++; $display("FAIL write_fabric: got %h required 00bb00dd", dout[95:64]);
        end
        bus_a(1'b0, 32'h8, 32'h0, 4'h0, 1'b0, r_ack, r_err, r_dat, r_rd, r_wr, r_late);
        n_checks++;
        if (r_dat !== 32'h00BB00DD || r_rd !== 4'b0100) begin
            n_fail++; $display("FAIL write_readback: dat=%h rd=%b required 00bb00dd 0100", r_dat, r_rd);
        end
        mdl[2] = 32'h00BB00DD;
        last_dat = 32'h00BB00DD;
    endtask

    task automatic test_errors();
        logic [31:0] r_dat;
        logic [3:0]  r_rd, r_wr;
        logic        r_ack, r_err, r_late;
        bus_a(1'b1, 32'h4, 32'hFFFFFFFF, 4'hF, 1'b0, r_ack, r_err, r_dat, r_rd, r_wr, r_late);
        n_checks++;
        if (r_err !== 1'b1 || r_ack !== 1'b0 || r_wr !== 4'h0 || r_dat !== 32'h0 || r_late !== 1'b0) begin
            n_fail++; $display("FAIL err_write_rdchan: err=%b ack=%b wr=%b dat=%h late=%b required 1 0 0 0 0",
                               r_err, r_ack, r_wr, r_dat, r_late);
        end
        bus_a(1'b0, 32'h4, 32'h0, 4'h0, 1'b0, r_ack, r_err, r_dat, r_rd, r_wr, r_late);
        n_checks++;
        if (r_dat !== mdl[1]) begin
            n_fail++; $display("FAIL err_ch1_unchanged: got %h required %h", r_dat, mdl[1]);
        end
        bus_a(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, r_ack, r_err, r_dat, r_rd, r_wr, r_late);
        n_checks++;
        if (r_err !== 1'b1 || r_ack !== 1'b0 || r_dat !== 32'h0 || r_rd !== 4'h0) begin
            n_fail++; $display("FAIL err_idx: err=%b ack=%b dat=%h rd=%b required 1 0 0 0",
                               r_err, r_ack, r_dat, r_rd);
        end
        bus_a(1'b0, 32'h10000, 32'h0, 4'h0, 1'b0, r_ack, r_err, r_dat, r_rd, r_wr, r_late);
        n_checks++;
        if (r_err !== 1'b1 || r_ack !== 1'b0) begin
            n_fail++; $display("FAIL err_range: err=%b ack=%b required 1 0", r_err, r_ack);
        end
        last_dat = 32'h0;
    endtask

    task automatic test_capture_same_edge();
        logic [31:0] r_dat;
        logic [3:0]  r_rd, r_wr;
        logic        r_ack, r_err, r_late;
        logic [31:0] old0;
        old0 = mdl[0];
        din[31:0] = 32'h5A5AC3C3;
        bus_a(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, r_ack, r_err, r_dat, r_rd, r_wr, r_late);
        mdl[0] = din[31:0]; mdl[1] = din[63:32];
        n_checks++;
        if (r_dat !== old0) begin
            n_fail++; $display("FAIL same_edge_old: got %h required %h", r_dat, old0);
        end
        bus_a(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, r_ack, r_err, r_dat, r_rd, r_wr, r_late);
        n_checks++;
        if (r_dat !== 32'h5A5AC3C3) begin
            n_fail++; $display("FAIL same_edge_new: got %h required 5a5ac3c3", r_dat);
        end
        last_dat = 32'h5A5AC3C3;
    endtask

    task automatic test_back_to_back();
        int acks = 0;
        int rds  = 0;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            acks += int'(ack);
            rds  += int'(rd_stb[0]);
        end
        cyc = 1'b0; stb = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            acks += int'(ack);
        end
        n_checks++;
        if (acks != 2 || rds != 2) begin
            n_fail++; $display("FAIL back_to_back: acks=%0d rd_stbs=%0d required 2 2", acks, rds);
        end
        last_dat = mdl[0];
    endtask

    task automatic test_random();
        logic [31:0] r_dat, a, d, exp_dat;
        logic [3:0]  r_rd, r_wr, s, exp_rd, exp_wr;
        logic        r_ack, r_err, r_late, w, c, exp_ack, exp_err;
        int          ch;
        for (int it = 0; it < 200; it++) begin
            din = {$urandom, $urandom, $urandom, $urandom};
            w = 1'($urandom_range(0, 1));
            c = ($urandom_range(0, 3) == 0);
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 7))
                5:       a = 32'h10 + 32'($urandom_range(0, 15));
                6:       a = 32'h10000 + 32'($urandom_range(0, 255));
                7:       a = $urandom;
                default: a = 32'($urandom_range(0, 15));
            endcase
            exp_ack = 1'b0; exp_err = 1'b0; exp_rd = 4'h0; exp_wr = 4'h0;
            if (a <= 32'hFFFF && (a / 4) < 4) begin
                ch = int'(a / 4);
                if (w && ch >= 2) begin
                    exp_ack = 1'b1; exp_wr = 4'(1 << ch);
                    mdl[ch] = lane_write(mdl[ch], d, s);
                end else if (w) begin
                    exp_err = 1'b1; last_dat = 32'h0;
                end else begin
                    exp_ack = 1'b1; exp_rd = 4'(1 << ch); last_dat = mdl[ch];
                end
            end else begin
                exp_err = 1'b1; last_dat = 32'h0;
            end
            if (c) begin
                mdl[0] = din[31:0]; mdl[1] = din[63:32];
            end
            exp_dat = last_dat;
            bus_a(w, a, d, s, c, r_ack, r_err, r_dat, r_rd, r_wr, r_late);
            n_checks++;
            if (r_ack !== exp_ack || r_err !== exp_err || r_dat !== exp_dat ||
                r_rd !== exp_rd || r_wr !== exp_wr || r_late !== 1'b0) begin
                n_fail++;
                $display("FAIL random[%0d] we=%b adr=%h: ack=%b err=%b dat=%h rd=%b wr=%b late=%b required %b %b %h %b %b 0",
                         it, w, a, r_ack, r_err, r_dat, r_rd, r_wr, r_late,
                         exp_ack, exp_err, exp_dat, exp_rd, exp_wr);
            end
            n_checks++;
            if (dout !== {mdl[3], mdl[2], 64'h0}) begin
                n_fail++; $display("FAIL random_fabric[%0d]: got %h required %h", it, dout,
                                   {mdl[3], mdl[2], 64'h0});
            end
        end
    endtask

    task automatic test_narrow();
        // Full-width write onto a 12-bit channel keeps only the low 12 bits.
        @(negedge clk);
        cyc_b = 1'b1; stb_b = 1'b1; we_b = 1'b1; adr_b = 32'h0; wdat_b = 32'hFFFFFFFF; sel_b = 4'hF;
        @(posedge clk); #1;
        n_checks++;
        if (ack_b !== 1'b1 || wr_stb_b !== 4'b0001) begin
            n_fail++; $display("FAIL narrow_write: ack=%b wr=%b required 1 0001", ack_b, wr_stb_b);
        end
        cyc_b = 1'b0; stb_b = 1'b0; we_b = 1'b0;
        @(negedge clk);
        @(negedge clk);
        cyc_b = 1'b1; stb_b = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (ack_b !== 1'b1 || dat_o_b !== 32'h00000FFF || dout_b[11:0] !== 12'hFFF) begin
            n_fail++; $display("FAIL narrow_readback: ack=%b dat=%h fab=%h required 1 00000fff fff",
                               ack_b, dat_o_b, dout_b[11:0]);
        end
        cyc_b = 1'b0; stb_b = 1'b0;
        // Reset asserted while the response to a write is being presented.
        @(negedge clk);
        @(negedge clk);
        cyc_b = 1'b1; stb_b = 1'b1; we_b = 1'b1; adr_b = 32'h4; wdat_b = 32'h00000ABC;
        @(posedge clk); #1;
        n_checks++;
        if (ack_b !== 1'b1 || dout_b[23:12] !== 12'hABC) begin
            n_fail++; $display("FAIL narrow_pre_reset: ack=%b ch1=%h required 1 abc", ack_b, dout_b[23:12]);
        end
        rst_n_b = 1'b0;
        #1;
        n_checks++;
        if (ack_b !== 1'b0 || err_b !== 1'b0 || wr_stb_b !== 4'h0) begin
            n_fail++; $display("FAIL narrow_reset_ack: ack=%b err=%b wr=%b required 0 0 0",
                               ack_b, err_b, wr_stb_b);
        end
        n_checks++;
        if (dout_b !== {4{12'h678}}) begin
            n_fail++; $display("FAIL narrow_reset_regs: got %h required %h", dout_b, {4{12'h678}});
        end
        cyc_b = 1'b0; stb_b = 1'b0; we_b = 1'b0;
        @(negedge clk);
        rst_n_b = 1'b1;
        @(negedge clk);
        cyc_b = 1'b1; stb_b = 1'b1; adr_b = 32'h4;
        @(posedge clk); #1;
        n_checks++;
        if (ack_b !== 1'b1 || dat_o_b !== 32'h00000678 || rd_stb_b !== 4'b0010) begin
            n_fail++; $display("FAIL narrow_after_reset: ack=%b dat=%h rd=%b required 1 00000678 0010",
                               ack_b, dat_o_b, rd_stb_b);
        end
        cyc_b = 1'b0; stb_b = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; cap = 1'b0;
        sel = 4'h0; adr = 32'h0; wdat = 32'h0; din = '0;
        rst_n_b = 1'b0; cyc_b = 1'b0; stb_b = 1'b0; we_b = 1'b0; cap_b = 1'b0;
        sel_b = 4'h0; adr_b = 32'h0; wdat_b = 32'h0; din_b = '0;
        last_dat = 32'h0;
        for (int i = 0; i < 4; i++) mdl[i] = 32'h12345678;
        test_reset();
        test_capture();
        test_write();
        test_errors();
        test_capture_same_edge();
        test_back_to_back();
        test_random();
        test_narrow();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
